// File: rtl/edge_pkg.sv
// Shared constants and FSM state type for the Sobel gradient stage.
// Tile geometry, output count and magnitude saturation limit live here.
package edge_pkg;

    localparam int TILE_W  = 4;
    localparam int N_OUT   = 4;
    localparam int MAG_SAT = 255;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LATCH   = 2'd1,
        COMPUTE = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/flex_counter.sv
// Generic up-counter with synchronous clear and enable; wraps at 2**WIDTH.
// Count is registered: one cycle from enable to new value.
module flex_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             count_en_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (count_en_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/gradient_filter.sv
// Sobel gradient magnitude and edge flags for the four centres of a 4x4 tile; start -> grad_valid in 6 cycles.
// Starts are ignored while busy. Optional dir_out when GRADIENT_DIRECTION_EN is defined.
module gradient_filter
    import edge_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [TILE_W*TILE_W*8-1:0]    blur_in,
    input  logic [7:0]                    threshold,
    output logic                          busy,
    output logic [N_OUT*8-1:0]            grad_out,
    output logic [N_OUT-1:0]              edge_out,
    output logic                          grad_valid
`ifdef GRADIENT_DIRECTION_EN
    ,
    output logic [N_OUT*2-1:0]            dir_out
`endif
);

    state_t state_q, state_d;
    logic [1:0] idx;

    logic [TILE_W*TILE_W*8-1:0] tile_q;
    logic [7:0]                 thr_q;
    logic [N_OUT*8-1:0]         grad_part_q, grad_nx, grad_out_q;
    logic [N_OUT-1:0]           edge_part_q, edge_nx, edge_out_q;

    logic [7:0]         p [0:2][0:2];
    logic [1:0]         rr [0:2];
    logic [1:0]         cc [0:2];
    logic [9:0]         lsum, rsum, tsum, bsum;
    logic signed [10:0] gx, gy;
    logic [10:0]        ngx, ngy;
    logic [9:0]         ax, ay;
    logic [11:0]        mag;
    logic [7:0]         sat;

    flex_counter #(.WIDTH(2)) u_idx (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (state_q == LATCH),
        .count_en_i (state_q == COMPUTE),
        .count_o    (idx)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = LATCH;
            LATCH:   state_d = COMPUTE;
            COMPUTE: if (idx == 2'd3) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // 3x3 window around centre (idx[1]+1, idx[0]+1)
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            rr[i] = {1'b0, idx[1]} + 2'(i);
            cc[i] = {1'b0, idx[0]} + 2'(i);
        end
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                p[i][j] = tile_q[{rr[i], cc[j], 3'b000} +: 8];
            end
        end
        lsum = 10'(p[0][0]) + {1'b0, p[1][0], 1'b0} + 10'(p[2][0]);
        rsum = 10'(p[0][2]) + {1'b0, p[1][2], 1'b0} + 10'(p[2][2]);
        tsum = 10'(p[0][0]) + {1'b0, p[0][1], 1'b0} + 10'(p[0][2]);
        bsum = 10'(p[2][0]) + {1'b0, p[2][1], 1'b0} + 10'(p[2][2]);
        gx   = $signed({1'b0, rsum}) - $signed({1'b0, lsum});
        gy   = $signed({1'b0, bsum}) - $signed({1'b0, tsum});
        ngx  = -gx;
        ngy  = -gy;
        ax   = gx[10] ? ngx[9:0] : gx[9:0];
        ay   = gy[10] ? ngy[9:0] : gy[9:0];
        mag  = {2'b00, ax} + {2'b00, ay};
        sat  = (mag > 12'(MAG_SAT)) ? 8'(MAG_SAT) : mag[7:0];

        grad_nx = grad_part_q;
        grad_nx[{idx, 3'b000} +: 8] = sat;
        edge_nx = edge_part_q;
        edge_nx[idx] = (sat >= thr_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            tile_q      <= '0;
            thr_q       <= '0;
            grad_part_q <= '0;
            edge_part_q <= '0;
            grad_out_q  <= '0;
            edge_out_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == LATCH) begin
                tile_q <= blur_in;
                thr_q  <= threshold;
            end
            // Visible outputs change only when the last centre lands.
            if (state_q == COMPUTE) begin
                grad_part_q <= grad_nx;
                edge_part_q <= edge_nx;
                if (idx == 2'd3) begin
                    grad_out_q <= grad_nx;
                    edge_out_q <= edge_nx;
                end
            end
        end
    end

`ifdef GRADIENT_DIRECTION_EN
    logic [1:0]         dir_cur;
    logic [N_OUT*2-1:0] dir_part_q, dir_nx, dir_out_q;

    always_comb begin
        if ({1'b0, ay, 1'b0} < {2'b00, ax}) begin
            dir_cur = 2'd0;
        end else if ({1'b0, ax, 1'b0} < {2'b00, ay}) begin
            dir_cur = 2'd1;
        end else if (gx[10] == gy[10]) begin
            dir_cur = 2'd2;
        end else begin
            dir_cur = 2'd3;
        end
        dir_nx = dir_part_q;
        dir_nx[{idx, 1'b0} +: 2] = dir_cur;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dir_part_q <= '0;
            dir_out_q  <= '0;
        end else if (state_q == COMPUTE) begin
            dir_part_q <= dir_nx;
            if (idx == 2'd3) dir_out_q <= dir_nx;
        end
    end

    assign dir_out = dir_out_q;
`endif

    assign busy       = (state_q != IDLE);
    assign grad_valid = (state_q == DONE);
    assign grad_out   = grad_out_q;
    assign edge_out   = edge_out_q;

endmodule

// File: tb/tb_gradient_filter.sv
// Directed bench for gradient_filter: per-cycle compare against a Sobel model plus literal checks.
// Build with GRADIENT_DIRECTION_EN defined to also exercise dir_out.
module tb_gradient_filter;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] blur_in;
    logic [7:0]   threshold;
    logic         busy;
    logic [31:0]  grad_out;
    logic [3:0]   edge_out;
    logic         grad_valid;
    logic [7:0]   dir_act;
`ifdef GRADIENT_DIRECTION_EN
    logic [7:0]   dir_out;
    assign dir_act = dir_out;
`else
    assign dir_act = 8'h00;
`endif

    gradient_filter dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .blur_in    (blur_in),
        .threshold  (threshold),
        .busy       (busy),
        .grad_out   (grad_out),
        .edge_out   (edge_out),
        .grad_valid (grad_valid)
`ifdef GRADIENT_DIRECTION_EN
        ,
        .dir_out    (dir_out)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model of a tile's result from the Sobel definition.
    task automatic model(input logic [127:0] t, input logic [7:0] thr,
                         output logic [31:0] g, output logic [3:0] e, output logic [7:0] d);
        int wx [3][3] = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
        int wy [3][3] = '{'{-1, -2, -1}, '{0, 0, 0}, '{1, 2, 1}};
        g = '0; e = '0; d = '0;
        for (int k = 0; k < 4; k++) begin
            int r, c, sx, sy, m, ax, ay, dv;
            r = 1 + k / 2; c = 1 + k % 2; sx = 0; sy = 0;
            for (int dr = -1; dr <= 1; dr++)
                for (int dc = -1; dc <= 1; dc++) begin
                    int pix;
                    pix = int'(t[8*((r+dr)*4 + (c+dc)) +: 8]);
                    sx += wx[dr+1][dc+1] * pix;
                    sy += wy[dr+1][dc+1] * pix;
                end
            ax = sx < 0 ? -sx : sx;
            ay = sy < 0 ? -sy : sy;
            m  = ax + ay;
            if (m > 255) m = 255;
            g[8*k +: 8] = 8'(m);
            e[k] = (m >= int'(thr));
            if (2 * ay < ax) dv = 0;
            else if (2 * ax < ay) dv = 1;
            else if ((sx < 0) == (sy < 0)) dv = 2;
            else dv = 3;
            d[2*k +: 2] = 2'(dv);
        end
    endtask

    function automatic logic [127:0] cols_tile(input logic [7:0] a, b, c, d);
        logic [7:0] v [4];
        logic [127:0] t;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        for (int r = 0; r < 4; r++)
            for (int cl = 0; cl < 4; cl++) t[8*(r*4+cl) +: 8] = v[cl];
        return t;
    endfunction

    function automatic logic [127:0] rows_tile(input logic [7:0] a, b, c, d);
        logic [7:0] v [4];
        logic [127:0] t;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        for (int r = 0; r < 4; r++)
            for (int cl = 0; cl < 4; cl++) t[8*(r*4+cl) +: 8] = v[r];
        return t;
    endfunction

    // Expected-behaviour state, written only by the driver process.
    bit          chk_en   = 0;
    bit          m_active = 0;
    int          m_start  = 0;
    int          m_valid_at = 0;
    logic [31:0] m_pend_g, m_hold_g = '0;
    logic [3:0]  m_pend_e, m_hold_e = '0;
    logic [7:0]  m_pend_d, m_hold_d = '0;

    always @(negedge clk) begin
        if (chk_en) begin
            bit fin, bsy;
            fin = m_active && (cyc >= m_valid_at);
            bsy = m_active && (cyc > m_start) && (cyc <= m_valid_at);
            chk("busy", 32'(busy), 32'(bsy));
            chk("grad_valid", 32'(grad_valid), 32'(m_active && cyc == m_valid_at));
            chk("grad_out", grad_out, fin ? m_pend_g : m_hold_g);
            chk("edge_out", 32'(edge_out), 32'(fin ? m_pend_e : m_hold_e));
`ifdef GRADIENT_DIRECTION_EN
            chk("dir_out", 32'(dir_act), 32'(fin ? m_pend_d : m_hold_d));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [127:0] t, input logic [7:0] thr);
        blur_in = t;
        threshold = thr;
        start = 1'b1;
        if (!(m_active && cyc <= m_valid_at)) begin
            if (m_active) begin
                m_hold_g = m_pend_g; m_hold_e = m_pend_e; m_hold_d = m_pend_d;
            end
            model(t, thr, m_pend_g, m_pend_e, m_pend_d);
            m_active = 1;
            m_start = cyc;
            m_valid_at = cyc + 6;
        end
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_active = 0;
        m_hold_g = '0; m_hold_e = '0; m_hold_d = '0;
    endtask

    // Waits for grad_valid, reporting cycles since st; a missed bound counts as a failure.
    task automatic wait_valid(input int st, output int lat);
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            if (grad_valid) begin
                lat = cyc - st;
                break;
            end
            tick();
        end
        chk("latency", 32'(lat), 32'd6);
    endtask

    initial begin
        logic [31:0] g;
        logic [3:0]  e;
        logic [7:0]  d;
        int st, lat, pulses;
        logic [127:0] ramp, step, flat;

        ramp = cols_tile(8'd0, 8'd10, 8'd20, 8'd30);
        step = cols_tile(8'd0, 8'd0, 8'd255, 8'd255);
        flat = cols_tile(8'd100, 8'd100, 8'd100, 8'd100);

        // Pin the model with hand-derived values.
        model(ramp, 8'd80, g, e, d);
        chk("model_ramp_g", g, 32'h50505050);
        chk("model_ramp_e", 32'(e), 32'hF);
        chk("model_ramp_d", 32'(d), 32'h00);
        model(rows_tile(8'd0, 8'd10, 8'd20, 8'd30), 8'd81, g, e, d);
        chk("model_vert_d", 32'(d), 32'h55);
        chk("model_vert_e", 32'(e), 32'h0);
        model(step, 8'd200, g, e, d);
        chk("model_step_g", g, 32'hFFFFFFFF);

        rst = 1'b1; start = 1'b0; blur_in = '0; threshold = '0;
        tick(); tick(); tick();
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(grad_valid), 32'd0);
        chk("rst_grad", grad_out, 32'd0);
        chk("rst_edge", 32'(edge_out), 32'd0);
        chk_en = 1;
        tick();

        st = cyc; do_start(flat, 8'd1); wait_valid(st, lat);
        chk("flat_grad", grad_out, 32'h0);
        chk("flat_edge", 32'(edge_out), 32'h0);
        tick(); tick();

        st = cyc; do_start(step, 8'd200); wait_valid(st, lat);
        chk("step_grad", grad_out, 32'hFFFFFFFF);
        chk("step_edge", 32'(edge_out), 32'hF);
        tick();

        st = cyc; do_start(ramp, 8'd80); wait_valid(st, lat);
        chk("ramp80_grad", grad_out, 32'h50505050);
        chk("ramp80_edge", 32'(edge_out), 32'hF);
        tick();

        st = cyc; do_start(ramp, 8'd81); wait_valid(st, lat);
        chk("ramp81_edge", 32'(edge_out), 32'h0);
`ifdef GRADIENT_DIRECTION_EN
        chk("ramp_dir", 32'(dir_act), 32'h00);
`endif
        tick();

        st = cyc; do_start(rows_tile(8'd0, 8'd10, 8'd20, 8'd30), 8'd80); wait_valid(st, lat);
        chk("vert_grad", grad_out, 32'h50505050);
`ifdef GRADIENT_DIRECTION_EN
        chk("vert_dir", 32'(dir_act), 32'h55);
`endif
        tick();

        // Second start at N+3 is ignored; inputs also change after LATCH.
        st = cyc; do_start(step, 8'd200);
        tick();
        blur_in = flat; threshold = 8'd0;
        tick();
        do_start(flat, 8'd0);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            if (grad_valid) begin
                pulses++;
                chk("overlap_when", 32'(cyc - st), 32'd6);
                chk("overlap_grad", grad_out, 32'hFFFFFFFF);
            end
            tick();
        end
        chk("overlap_pulses", 32'(pulses), 32'd1);

        // Start held high through DONE must not launch another tile.
        st = cyc; do_start(ramp, 8'd80);
        while (cyc < st + 6) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("done_start_busy", 32'(busy), 32'd0);
        tick();

        // Reset at N+4 aborts; restart at N+6 completes at N+12.
        st = cyc; do_start(step, 8'd10);
        while (cyc < st + 4) tick();
        do_reset();
        pulses = 0;
        tick();
        chk("abort_grad", grad_out, 32'h0);
        chk("abort_edge", 32'(edge_out), 32'h0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("restart_cycle", 32'(cyc - st), 32'd6);
        do_start(ramp, 8'd80);
        for (int i = 0; i < 7; i++) begin
            if (grad_valid) pulses++;
            if (grad_valid) chk("restart_when", 32'(cyc - st), 32'd12);
            tick();
        end
        chk("restart_pulses", 32'(pulses), 32'd1);

        for (int n = 0; n < 4; n++) begin
            logic [127:0] t;
            for (int b = 0; b < 4; b++) t[32*b +: 32] = $urandom;
            st = cyc; do_start(t, 8'($urandom_range(0, 255)));
            wait_valid(st, lat);
            tick();
        end

        tick(); tick();
        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
